// File: rtl/spi_device_slave.sv
// SPI mode-0 device endpoint: oversamples SCLK/SS/MOSI in the clk_i domain, returns MISO
// characters from a one-entry tx buffer and presents received characters with a valid/ready handshake.
module spi_device_slave #(
    parameter int unsigned CHAR_LEN    = 8,
    parameter bit          LSB_FIRST   = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sclk_i,
    input  logic                ss_ni,
    input  logic                sd_i,
    output logic                sd_o,
    output logic                sd_oe,
    output logic [CHAR_LEN-1:0] rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                rx_overflow_o,
    input  logic [CHAR_LEN-1:0] tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic                tx_underrun_o,
    output logic                busy_o
);

    localparam int unsigned CW = $clog2(CHAR_LEN);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, sd_sync;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, ss_s, sd_s;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic [CW-1:0]          bit_cnt;
    logic [CHAR_LEN-1:0]    rx_shift, rx_next, rx_word;
    logic [CHAR_LEN-1:0]    tx_shift, tx_shifted, tx_buf;
    logic                   tx_bit, tx_full, tx_load, tx_accept, last_bit;
    logic                   rx_done, sd_oe_q, busy_q, underrun_q;
    logic [CHAR_LEN-1:0]    rx_data_q;
    logic                   rx_valid_q, overflow_q;

    // Input synchronisers; ss chain resets to the inactive level so reset never fakes a frame start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            sd_sync   <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_ni};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sd_i};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sd_s      = sd_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;

    always_comb begin
        rx_next    = '0;
        tx_shifted = '0;
        tx_bit     = 1'b0;
        if (LSB_FIRST) begin
            rx_next    = {sd_s, rx_shift[CHAR_LEN-1:1]};
            tx_shifted = {1'b0, tx_shift[CHAR_LEN-1:1]};
            tx_bit     = tx_shift[0];
        end else begin
            rx_next    = {rx_shift[CHAR_LEN-2:0], sd_s};
            tx_shifted = {tx_shift[CHAR_LEN-2:0], 1'b0};
            tx_bit     = tx_shift[CHAR_LEN-1];
        end
    end

    assign last_bit  = (bit_cnt == CW'(CHAR_LEN - 1));
    assign tx_accept = tx_valid_i & ~tx_full;
    assign tx_load   = ((state == IDLE) && ss_fall) ||
                       ((state == ACTIVE) && !ss_rise && sclk_fall && (bit_cnt == '0));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            rx_word    <= '0;
            tx_shift   <= '0;
            rx_done    <= 1'b0;
            sd_oe_q    <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rx_done    <= 1'b0;
            underrun_q <= 1'b0;
            if (tx_load) begin
                tx_shift   <= tx_full ? tx_buf : '0;
                underrun_q <= ~tx_full;
            end
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (ss_fall) begin
                        state   <= ACTIVE;
                        sd_oe_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        // Abort: a partial character is simply forgotten.
                        state    <= IDLE;
                        sd_oe_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next;
                        if (last_bit) begin
                            bit_cnt <= '0;
                            rx_word <= rx_next;
                            rx_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (sclk_fall && (bit_cnt != '0)) begin
                        tx_shift <= tx_shifted;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A load from an empty buffer and an accept in the same cycle leave the new data buffered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_full <= 1'b0;
            tx_buf  <= '0;
        end else begin
            if (tx_load && tx_full) tx_full <= 1'b0;
            if (tx_accept) begin
                tx_full <= 1'b1;
                tx_buf  <= tx_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (rx_done) begin
                if (!rx_valid_q || rx_ready_i) begin
                    rx_data_q  <= rx_word;
                    rx_valid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign sd_o          = sd_oe_q & tx_bit;
    assign sd_oe         = sd_oe_q;
    assign busy_o        = busy_q;
    assign tx_ready_o    = ~tx_full;
    assign tx_underrun_o = underrun_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_overflow_o = overflow_q;

endmodule

// File: tb/tb_spi_device_slave.sv
// Bench for spi_device_slave: bit-banged SPI master driving an 8-bit MSB-first and a
// 16-bit LSB-first instance, checked against a character-level model of the link.
module tb_spi_device_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0, sd_mosi = 1'b0, ss_a = 1'b1, ss_b = 1'b1;
    logic        sel_b = 1'b0;

    logic        sd_o_a, sd_oe_a, rx_valid_a, rx_ovf_a, tx_ready_a, tx_und_a, busy_a;
    logic [7:0]  rx_data_a, tx_data_a = '0;
    logic        rx_ready_a = 1'b0, tx_valid_a = 1'b0;

    logic        sd_o_b, sd_oe_b, rx_valid_b, rx_ovf_b, tx_ready_b, tx_und_b, busy_b;
    logic [15:0] rx_data_b, tx_data_b = '0;
    logic        rx_ready_b = 1'b0, tx_valid_b = 1'b0;

    logic        miso_sel, rxv_sel;
    int          checks = 0, errors = 0;
    int          ovf_cnt_a = 0, und_cnt_a = 0, acc_cnt_a = 0, und_cnt_b = 0;

    always #5 clk = ~clk;

    spi_device_slave #(.CHAR_LEN(8), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .ss_ni(ss_a), .sd_i(sd_mosi),
        .sd_o(sd_o_a), .sd_oe(sd_oe_a), .rx_data_o(rx_data_a), .rx_valid_o(rx_valid_a),
        .rx_ready_i(rx_ready_a), .rx_overflow_o(rx_ovf_a), .tx_data_i(tx_data_a),
        .tx_valid_i(tx_valid_a), .tx_ready_o(tx_ready_a), .tx_underrun_o(tx_und_a),
        .busy_o(busy_a));

    spi_device_slave #(.CHAR_LEN(16), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .ss_ni(ss_b), .sd_i(sd_mosi),
        .sd_o(sd_o_b), .sd_oe(sd_oe_b), .rx_data_o(rx_data_b), .rx_valid_o(rx_valid_b),
        .rx_ready_i(rx_ready_b), .rx_overflow_o(rx_ovf_b), .tx_data_i(tx_data_b),
        .tx_valid_i(tx_valid_b), .tx_ready_o(tx_ready_b), .tx_underrun_o(tx_und_b),
        .busy_o(busy_b));

    assign miso_sel = sel_b ? sd_o_b : sd_o_a;
    assign rxv_sel  = sel_b ? rx_valid_b : rx_valid_a;

    always @(posedge clk) begin
        if (!rst) begin
            if (rx_ovf_a) ovf_cnt_a++;
            if (tx_und_a) und_cnt_a++;
            if (tx_und_b) und_cnt_b++;
            if (rx_valid_a && rx_ready_a) acc_cnt_a++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input int inst, input logic [31:0] w);
        if (inst == 0) begin tx_data_a = w[7:0]; tx_valid_a = 1'b1; end
        else begin tx_data_b = w[15:0]; tx_valid_b = 1'b1; end
        cyc(1);
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
    endtask

    task automatic frame_start(input int inst);
        if (inst == 0) ss_a = 1'b0; else ss_b = 1'b0;
        cyc(8);
    endtask

    // SS is released while SCLK is still high, so the idle-low return of SCLK triggers no load.
    task automatic frame_end(input int inst);
        if (inst == 0) ss_a = 1'b1; else ss_b = 1'b1;
        cyc(4);
        sclk = 1'b0;
        cyc(8);
    endtask

    // Master side of one character at clk/8: data set with SCLK low, MISO sampled just before the rise.
    task automatic send_char(input int inst, input logic [31:0] mosi, input int nbits,
                             input bit lsb, input bit push, input logic [31:0] push_word,
                             output logic [31:0] miso, output int lat);
        int idx;
        miso  = '0;
        lat   = 0;
        sel_b = (inst != 0);
        for (int i = 0; i < nbits; i++) begin
            idx     = lsb ? i : nbits - 1 - i;
            sclk    = 1'b0;
            sd_mosi = mosi[idx];
            cyc(4);
            miso[idx] = miso_sel;
            sclk = 1'b1;
            if (push && i == 1) begin
                push_tx(inst, push_word);
                cyc(3);
            end else if (i == nbits - 1) begin
                for (int k = 1; k <= 4; k++) begin
                    cyc(1);
                    if (lat == 0 && rxv_sel) lat = k;
                end
            end else begin
                cyc(4);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_outs"}, {31'(0), sd_o_a | sd_oe_a | rx_valid_a | rx_ovf_a | tx_und_a | busy_a}, 32'h0);
        check({tag, "_a_data"}, {24'h0, rx_data_a}, 32'h0);
        check({tag, "_a_txrdy"}, {31'(0), tx_ready_a}, 32'h1);
        check({tag, "_b_outs"}, {31'(0), sd_o_b | sd_oe_b | rx_valid_b | rx_ovf_b | tx_und_b | busy_b}, 32'h0);
        check({tag, "_b_txrdy"}, {31'(0), tx_ready_b}, 32'h1);
    endtask

    initial begin
        logic [31:0] miso;
        int          lat, o0, u0, a0;
        logic [7:0]  mw [3];
        logic [7:0]  tw [3];
        bit          pre [3];
        bit          rdy, m_valid;
        logic [7:0]  m_data;
        int          n, exp_ovf, exp_und, exp_acc;

        // Reset state
        cyc(2);
        check_reset_outputs("rst");
        rst = 1'b0;
        cyc(4);

        // Preloaded tx 0xA5, master sends 0x3C MSB first
        push_tx(0, 32'hA5);
        check("tx_ready_drop", {31'(0), tx_ready_a}, 32'h0);
        u0 = und_cnt_a;
        frame_start(0);
        check("busy_active", {30'(0), busy_a, sd_oe_a}, 32'h3);
        send_char(0, 32'h3C, 8, 1'b0, 1'b0, 32'h0, miso, lat);
        frame_end(0);
        check("miso_a5", miso, 32'hA5);
        check("rx_3c", {24'h0, rx_data_a}, 32'h3C);
        check("rx_valid_3c", {31'(0), rx_valid_a}, 32'h1);
        check("rx_latency", lat, 32'd4);
        check("no_underrun", und_cnt_a - u0, 32'd0);
        check("idle_outs", {30'(0), busy_a, sd_oe_a}, 32'h0);
        rx_ready_a = 1'b1;
        cyc(1);
        check("rx_accept", {31'(0), rx_valid_a}, 32'h0);
        rx_ready_a = 1'b0;

        // Back-to-back characters with the consumer stalled
        o0 = ovf_cnt_a;
        frame_start(0);
        send_char(0, 32'h11, 8, 1'b0, 1'b0, 32'h0, miso, lat);
        send_char(0, 32'h22, 8, 1'b0, 1'b0, 32'h0, miso, lat);
        frame_end(0);
        check("ovf_keep", {24'h0, rx_data_a}, 32'h11);
        check("ovf_valid", {31'(0), rx_valid_a}, 32'h1);
        check("ovf_pulses", ovf_cnt_a - o0, 32'd1);
        rx_ready_a = 1'b1;
        cyc(2);

        // No tx preload: zeros on MISO, one underrun at the ss fall
        u0 = und_cnt_a;
        frame_start(0);
        check("und_at_ss", und_cnt_a - u0, 32'd1);
        send_char(0, 32'($urandom_range(0, 255)), 8, 1'b0, 1'b0, 32'h0, miso, lat);
        frame_end(0);
        check("und_miso", miso, 32'h0);
        check("und_total", und_cnt_a - u0, 32'd1);

        // Abort after 5 bits, then a full 0x5A frame
        rx_ready_a = 1'b0;
        o0 = ovf_cnt_a;
        frame_start(0);
        send_char(0, 32'h1F, 5, 1'b0, 1'b0, 32'h0, miso, lat);
        frame_end(0);
        check("abort_valid", {31'(0), rx_valid_a}, 32'h0);
        check("abort_idle", {30'(0), busy_a, sd_oe_a}, 32'h0);
        check("abort_ovf", ovf_cnt_a - o0, 32'd0);
        frame_start(0);
        send_char(0, 32'h5A, 8, 1'b0, 1'b0, 32'h0, miso, lat);
        frame_end(0);
        check("after_abort", {24'h0, rx_data_a}, 32'h5A);
        rx_ready_a = 1'b1;
        cyc(2);
        rx_ready_a = 1'b0;

        // Reset in the middle of a frame with a buffered tx word
        frame_start(0);
        push_tx(0, 32'h77);
        send_char(0, 32'h3, 3, 1'b0, 1'b0, 32'h0, miso, lat);
        rst  = 1'b1;
        ss_a = 1'b1;
        sclk = 1'b0;
        cyc(2);
        check_reset_outputs("midrst");
        rst = 1'b0;
        cyc(8);

        // 16-bit LSB-first instance
        push_tx(1, 32'hBEEF);
        u0 = und_cnt_b;
        frame_start(1);
        send_char(1, 32'h1234, 16, 1'b1, 1'b0, 32'h0, miso, lat);
        frame_end(1);
        check("b_miso", miso, 32'hBEEF);
        check("b_rx", {16'h0, rx_data_b}, 32'h1234);
        check("b_valid", {31'(0), rx_valid_b}, 32'h1);
        check("b_und", und_cnt_b - u0, 32'd0);

        // Randomized frames against the character-level model
        m_valid = 1'b0;
        m_data  = rx_data_a;
        for (int f = 0; f < 8; f++) begin
            rdy = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 3);
            exp_ovf = 0;
            exp_und = 0;
            exp_acc = 0;
            for (int k = 0; k < 3; k++) begin
                mw[k]  = 8'($urandom);
                tw[k]  = 8'($urandom);
                pre[k] = 1'($urandom_range(0, 1));
            end
            rx_ready_a = rdy;
            if (pre[0]) push_tx(0, {24'h0, tw[0]});
            o0 = ovf_cnt_a;
            u0 = und_cnt_a;
            a0 = acc_cnt_a;
            frame_start(0);
            for (int k = 0; k < n; k++) begin
                send_char(0, {24'h0, mw[k]}, 8, 1'b0, (k + 1 < n) && pre[k+1],
                          {24'h0, tw[(k + 1) % 3]}, miso, lat);
                check("rnd_miso", miso, pre[k] ? {24'h0, tw[k]} : 32'h0);
                if (!pre[k]) exp_und++;
                if (rdy) begin
                    m_data = mw[k];
                    exp_acc++;
                end else if (!m_valid) begin
                    m_data  = mw[k];
                    m_valid = 1'b1;
                end else begin
                    exp_ovf++;
                end
                check("rnd_rx", {24'h0, rx_data_a}, {24'h0, m_data});
            end
            frame_end(0);
            check("rnd_valid", {31'(0), rx_valid_a}, {31'(0), m_valid});
            check("rnd_ovf", ovf_cnt_a - o0, exp_ovf);
            check("rnd_und", und_cnt_a - u0, exp_und);
            check("rnd_acc", acc_cnt_a - a0, exp_acc);
            rx_ready_a = 1'b1;
            cyc(2);
            rx_ready_a = 1'b0;
            m_valid = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
